// File: rtl/line_window_buffer.sv
// Purpose : multi-row sliding window of image rows for blur/detect filter stages.
// Latency : a captured row appears on slot0 one cycle after the edge; slot i after i+1 advances.
// Backpress: none; buffer_we qualifies rows, HOLD freezes the window indefinitely.
module line_window_buffer #(
  parameter int ROW_W = 5120,
  parameter int DEPTH = 10,
  parameter int N_SRC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 buffer_mode,
  input  logic                       buffer_we,
  input  logic [ROW_W-1:0]           img_data,
  input  logic [N_SRC*ROW_W-1:0]     blur_data,
  output logic [DEPTH*ROW_W-1:0]     buffer_data,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       win_valid
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] TWO_CNT  = CW'(2);

  // Detect-filter layout needs the image pair plus one pair per blur source.
  generate
    if (DEPTH < 2*N_SRC + 2) begin : g_depth_check
      $error("line_window_buffer: DEPTH must be >= 2*N_SRC+2");
    end
  endgenerate

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_GAUSS  = 2'd1,
    M_DETECT = 2'd2,
    M_HOLD   = 2'd3
  } mode_e;

  mode_e                          mode;
  mode_e                          prev_mode;
  logic [DEPTH-1:0][ROW_W-1:0]    slots_q;
  logic [DEPTH-1:0][ROW_W-1:0]    slots_d;
  logic [CW-1:0]                  fill_d;
  logic                           win_d;
  logic                           advance;
  logic                           mode_change;

  // Decode the raw mode; encodings 3..7 all freeze the window.
  always_comb begin
    case (buffer_mode)
      3'd0:    mode = M_IDLE;
      3'd1:    mode = M_GAUSS;
      3'd2:    mode = M_DETECT;
      default: mode = M_HOLD;
    endcase
  end

  // HOLD is transparent to mode tracking, so prev_mode never holds M_HOLD;
  // entering or leaving HOLD therefore never looks like a mode change.
  assign advance     = (mode == M_GAUSS) || ((mode == M_DETECT) && buffer_we);
  assign mode_change = (mode != M_HOLD) && (mode != prev_mode);

  // Next-state slot contents for each mode.
  always_comb begin
    slots_d = slots_q;
    case (mode)
      M_IDLE: begin
        slots_d = '0;
      end
      M_GAUSS: begin
        // Shift every cycle; a missing row shifts in zeros.
        slots_d[0] = buffer_we ? img_data : '0;
        for (int i = 1; i < DEPTH; i++) begin
          slots_d[i] = slots_q[i-1];
        end
      end
      M_DETECT: begin
        // Each source owns a two-deep pair: newest row, then previous row.
        if (buffer_we) begin
          slots_d[0] = img_data;
          slots_d[1] = slots_q[0];
          for (int k = 0; k < N_SRC; k++) begin
            slots_d[2*k+2] = blur_data[k*ROW_W +: ROW_W];
            slots_d[2*k+3] = slots_q[2*k+2];
          end
        end
      end
      default: begin
        slots_d = slots_q;
      end
    endcase
  end

  // Next-state fill count: restart on a mode change, saturate at DEPTH.
  always_comb begin
    fill_d = fill_cnt;
    if (mode == M_IDLE) begin
      fill_d = '0;
    end else if (mode == M_HOLD) begin
      fill_d = fill_cnt;
    end else if (mode_change) begin
      fill_d = advance ? ONE_CNT : '0;
    end else if (advance && (fill_cnt != FULL_CNT)) begin
      fill_d = fill_cnt + ONE_CNT;
    end
  end

  // Window-complete flag derived from the fill count being registered this edge.
  always_comb begin
    case (mode)
      M_GAUSS:  win_d = (fill_d == FULL_CNT);
      M_DETECT: win_d = (fill_d >= TWO_CNT);
      M_HOLD:   win_d = win_valid;
      default:  win_d = 1'b0;
    endcase
  end

  // State registers; reset empties the window and forgets the previous mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q   <= '0;
      fill_cnt  <= '0;
      win_valid <= 1'b0;
      prev_mode <= M_IDLE;
    end else begin
      slots_q   <= slots_d;
      fill_cnt  <= fill_d;
      win_valid <= win_d;
      if (mode != M_HOLD) begin
        prev_mode <= mode;
      end
    end
  end

  assign buffer_data = slots_q;

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter ROW_W, default 5120: bits per buffered row.
REQ-003 Parameter DEPTH, default 10: number of row slots.
REQ-004 Parameter N_SRC, default 4: number of blur-source inputs; DEPTH SHALL be >= 2*N_SRC+2, checked at elaboration.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 buffer_mode  in  3  0 IDLE, 1 GAUSSIAN, 2 DETECT_FILTER, 3 HOLD; values 4-7 are treated as HOLD.
REQ-008 buffer_we  in  1  row write strobe.
REQ-009 img_data  in  ROW_W  image row from SRAM.
REQ-010 blur_data  in  N_SRC*ROW_W  flattened blur rows; source k is in bits [k*ROW_W +: ROW_W].
REQ-011 buffer_data  out  DEPTH*ROW_W  flattened row slots; slot i is in bits [i*ROW_W +: ROW_W]; registered.
REQ-012 fill_cnt  out  $clog2(DEPTH+1)  number of row advances since the last clear; registered.
REQ-013 win_valid  out  1  the window is complete for the current mode; registered.

Function
REQ-014 IDLE: all slots SHALL be 0, fill_cnt SHALL be 0 and win_valid SHALL be 0 on the next edge.
REQ-015 GAUSSIAN, every cycle: slot0 <= buffer_we ? img_data : 0; slot i <= slot i-1 for 1 <= i < DEPTH.
REQ-016 DETECT_FILTER, buffer_we=1:
- slot0 <= img_data; slot1 <= slot0.
- For k < N_SRC: slot 2k+2 <= source k; slot 2k+3 <= slot 2k+2.
- Slots >= 2*N_SRC+2 hold.
REQ-017 DETECT_FILTER, buffer_we=0: all slots, fill_cnt and win_valid SHALL hold.
REQ-018 HOLD: all slots, fill_cnt and win_valid SHALL hold regardless of buffer_we.
REQ-019 A row advance is every GAUSSIAN cycle, or a DETECT_FILTER cycle with buffer_we=1.
REQ-020 fill_cnt SHALL increment by 1 per row advance and saturate at DEPTH; it never wraps.
REQ-021 The block SHALL register the previous mode. On the first cycle of a mode differing from the previous mode (excluding a change into or out of HOLD):
- fill_cnt SHALL load 1 if that cycle is a row advance, else 0.
- Slot data SHALL follow REQ-015/016 normally.
REQ-022 win_valid SHALL be computed from the next-state fill_cnt and take effect on the same edge as fill_cnt:
- 1 when (mode GAUSSIAN and next fill_cnt = DEPTH), or
- 1 when (mode DETECT_FILTER and next fill_cnt >= 2).
- In HOLD it keeps its prior value; otherwise it is 0.
REQ-023 Zero-insert shifts in GAUSSIAN (buffer_we=0) SHALL count as row advances.
REQ-024 Latency: an input row SHALL appear on slot0 one cycle after the capturing edge, and on slot i after i+1 advances (GAUSSIAN).

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously clear all slots, fill_cnt, win_valid and the registered previous mode (to IDLE) to 0.
REQ-026 A reset asserted mid-operation SHALL discard all contents; the first edge after release SHALL behave as if the previous mode were IDLE.
REQ-027 Reset release SHALL be synchronised externally; the block adds no synchroniser.

Verification
Parameters for all scenarios: ROW_W=8, DEPTH=6, N_SRC=2.
REQ-028 GAUSSIAN, we=1, img=1..6 on successive cycles -> after the 6th edge slots0..5 = 6,5,4,3,2,1; fill_cnt=6; win_valid=1; a 7th cycle gives fill_cnt=6 (saturated).
REQ-029 GAUSSIAN, we alternating 1/0 with img=A,B -> slot0 sequence A,0,B,0; fill_cnt increments every cycle.
REQ-030 DETECT_FILTER, two we pulses with img=10,11, src0=20,21, src1=30,31 -> slots0..5 = 11,10,21,20,31,30; win_valid=1 after the 2nd pulse. A we=0 cycle between the pulses holds all slots.
REQ-031 GAUSSIAN with fill_cnt=6, then switch to DETECT_FILTER with we=1 -> fill_cnt=1 and win_valid=0 on that edge.
REQ-032 HOLD for 5 cycles with we toggling -> slots, fill_cnt and win_valid unchanged.
REQ-033 rst_n pulsed low between clock edges mid-GAUSSIAN -> outputs are 0 immediately; after release, the first GAUSSIAN we=1 cycle gives fill_cnt=1.
